// File: rtl/instruction_queue.sv
// instruction_queue: DEPTH-entry FIFO of WIDTH-bit instruction words sitting
// between fetch and decode. Valid/ready on both sides, occupancy count, and a
// synchronous flush used on branch redirects.
module instruction_queue #(
  parameter  int WIDTH = 26,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             flush,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             push;
  logic             pop;

  // Ready while not full (independent of outReady); valid while not empty.
  assign inReady  = (count != CW'(DEPTH));
  assign outValid = (count != '0);
  assign outData  = mem[rdPtr];

  assign push = inValid && inReady;
  assign pop  = outValid && outReady;

  // Pointer, occupancy and storage update; flush outranks push and pop.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as-is; only the bookkeeping is discarded.
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= inData;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed checks on the default 26x4 queue plus a
// randomised scoreboard run on a 32x8 instance.
module tb_instruction_queue;

  logic        clk = 1'b0;
  logic        resetN;

  // Default-parameter instance (WIDTH=26, DEPTH=4).
  logic        flush;
  logic [25:0] inData;
  logic        inValid;
  logic        inReady;
  logic [25:0] outData;
  logic        outValid;
  logic        outReady;
  logic [2:0]  count;

  // Wide instance (WIDTH=32, DEPTH=8).
  logic        flush2;
  logic [31:0] inData2;
  logic        inValid2;
  logic        inReady2;
  logic [31:0] outData2;
  logic        outValid2;
  logic        outReady2;
  logic [3:0]  count2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  instruction_queue #(.WIDTH(26), .DEPTH(4)) dut (
    .clk(clk), .resetN(resetN), .flush(flush),
    .inData(inData), .inValid(inValid), .inReady(inReady),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .count(count)
  );

  instruction_queue #(.WIDTH(32), .DEPTH(8)) dut8 (
    .clk(clk), .resetN(resetN), .flush(flush2),
    .inData(inData2), .inValid(inValid2), .inReady(inReady2),
    .outData(outData2), .outValid(outValid2), .outReady(outReady2),
    .count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    // Status packed as {outValid, inReady, count}.
    logic [4:0] st;
    resetN = 1'b1;
    idle_inputs();
    flush2 = 1'b0; inValid2 = 1'b0; inData2 = '0; outReady2 = 1'b0;
    tick();
    #2 resetN = 1'b0;
    #1;
    st = {outValid, inReady, count};
    tests_run++;
    if (st !== 5'b01_000) begin
      tests_failed++;
      $display("FAIL reset_status got=%b exp=%b", st, 5'b01_000);
    end
    tests_run++;
    if (outData !== 26'h0) begin
      tests_failed++;
      $display("FAIL reset_outdata got=%h exp=0", outData);
    end
    tests_run++;
    if ({outValid2, inReady2, count2} !== 6'b01_0000) begin
      tests_failed++;
      $display("FAIL reset_status8 got=%b exp=010000", {outValid2, inReady2, count2});
    end
    tick();
    resetN = 1'b1;
    tick();
    tests_run++;
    if ({outValid, inReady, count} !== 5'b01_000) begin
      tests_failed++;
      $display("FAIL reset_idle got=%b exp=%b", {outValid, inReady, count}, 5'b01_000);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      inValid = 1'b1;
      inData  = 26'(i);
      tick();
      tests_run++;
      if (count !== 3'(i)) begin
        tests_failed++;
        $display("FAIL fill_count%0d got=%0d exp=%0d", i, count, i);
      end
    end
    tests_run++;
    if (inReady !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_inready got=%b exp=0", inReady);
    end
    inData = 26'h5;
    tick();
    tests_run++;
    if (count !== 3'd4 || outData !== 26'h1) begin
      tests_failed++;
      $display("FAIL full_push_ignored count=%0d head=%h exp count=4 head=1", count, outData);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tests_run++;
      if (outValid !== 1'b1 || outData !== 26'(i)) begin
        tests_failed++;
        $display("FAIL drain_word%0d got v=%b d=%h exp v=1 d=%h", i, outValid, outData, 26'(i));
      end
      tick();
    end
    tests_run++;
    if (outValid !== 1'b0 || count !== 3'd0) begin
      tests_failed++;
      $display("FAIL drain_empty got v=%b count=%0d exp v=0 count=0", outValid, count);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    inValid = 1'b1;
    inData  = 26'h10; tick();
    inData  = 26'h11; tick();
    outReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      inData = 26'(8'h12 + k);
      tests_run++;
      if (outData !== 26'(8'h10 + k)) begin
        tests_failed++;
        $display("FAIL b2b_head%0d got=%h exp=%h", k, outData, 26'(8'h10 + k));
      end
      tick();
      tests_run++;
      if (count !== 3'd2) begin
        tests_failed++;
        $display("FAIL b2b_count%0d got=%0d exp=2", k, count);
      end
    end
    inValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (outData !== 26'(8'h16 + k)) begin
        tests_failed++;
        $display("FAIL b2b_tail%0d got=%h exp=%h", k, outData, 26'(8'h16 + k));
      end
      tick();
    end
    tests_run++;
    if (outValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_empty got=%b exp=0", outValid);
    end
    idle_inputs();
  endtask

  task automatic test_full_pop();
    inValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inData = 26'(8'hA0 + i);
      tick();
    end
    inData   = 26'hA4;
    outReady = 1'b1;
    tick();
    tests_run++;
    if (count !== 3'd3 || inReady !== 1'b1 || outData !== 26'hA1) begin
      tests_failed++;
      $display("FAIL fullpop_reject got count=%0d rdy=%b head=%h exp count=3 rdy=1 head=a1", count, inReady, outData);
    end
    outReady = 1'b0;
    tick();
    tests_run++;
    if (count !== 3'd4) begin
      tests_failed++;
      $display("FAIL fullpop_accept got=%0d exp=4", count);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tests_run++;
      if (outData !== 26'(8'hA0 + i)) begin
        tests_failed++;
        $display("FAIL fullpop_order%0d got=%h exp=%h", i, outData, 26'(8'hA0 + i));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inData = 26'(8'hB0 + i);
      tick();
    end
    tests_run++;
    if (count !== 3'd3) begin
      tests_failed++;
      $display("FAIL flush_precount got=%0d exp=3", count);
    end
    flush    = 1'b1;
    inData   = 26'h3FFFFFF;
    outReady = 1'b1;
    tick();
    tests_run++;
    if ({outValid, inReady, count} !== 5'b01_000) begin
      tests_failed++;
      $display("FAIL flush_clear got=%b exp=%b", {outValid, inReady, count}, 5'b01_000);
    end
    flush    = 1'b0;
    outReady = 1'b0;
    inData   = 26'h0ABC;
    tick();
    inValid = 1'b0;
    tests_run++;
    if (outValid !== 1'b1 || outData !== 26'h0ABC || count !== 3'd1) begin
      tests_failed++;
      $display("FAIL flush_newhead got v=%b d=%h c=%0d exp v=1 d=abc c=1", outValid, outData, count);
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (outValid !== 1'b0 || count !== 3'd0) begin
      tests_failed++;
      $display("FAIL flush_empty got v=%b c=%0d exp v=0 c=0", outValid, count);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    inValid = 1'b1;
    inData  = 26'h21; tick();
    inData  = 26'h22; tick();
    inValid = 1'b0;
    #2 resetN = 1'b0;
    #1;
    tests_run++;
    if ({outValid, inReady, count} !== 5'b01_000 || outData !== 26'h0) begin
      tests_failed++;
      $display("FAIL midreset got st=%b d=%h exp st=01000 d=0", {outValid, inReady, count}, outData);
    end
    tick();
    resetN  = 1'b1;
    inValid = 1'b1;
    inData  = 26'h55;
    tick();
    inValid = 1'b0;
    tests_run++;
    if (outData !== 26'h55 || count !== 3'd1) begin
      tests_failed++;
      $display("FAIL midreset_cold got d=%h c=%0d exp d=55 c=1", outData, count);
    end
    outReady = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_sweep();
    logic [31:0] q[$];
    int          mcount;
    bit          pu;
    bit          po;
    mcount = 0;
    for (int i = 0; i < 1000; i++) begin
      inValid2  = ($urandom_range(0, 3) < ((i % 200) < 100 ? 3 : 1));
      outReady2 = ($urandom_range(0, 3) < ((i % 200) < 100 ? 1 : 3));
      inData2   = $urandom;
      tests_run++;
      if (count2 !== 4'(mcount) || count2 > 4'd8) begin
        tests_failed++;
        $display("FAIL sweep_count cyc%0d got=%0d exp=%0d", i, count2, mcount);
      end
      tests_run++;
      if (outValid2 !== (mcount != 0) || inReady2 !== (mcount != 8)) begin
        tests_failed++;
        $display("FAIL sweep_flags cyc%0d got v=%b r=%b exp v=%b r=%b", i, outValid2, inReady2, mcount != 0, mcount != 8);
      end
      if (mcount != 0) begin
        tests_run++;
        if (outData2 !== q[0]) begin
          tests_failed++;
          $display("FAIL sweep_data cyc%0d got=%h exp=%h", i, outData2, q[0]);
        end
      end
      pu = inValid2 && (mcount != 8);
      po = outReady2 && (mcount != 0);
      tick();
      if (po) void'(q.pop_front());
      if (pu) q.push_back(inData2);
      mcount = mcount + (pu ? 1 : 0) - (po ? 1 : 0);
    end
    inValid2  = 1'b0;
    outReady2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_pop();
    test_flush();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
